// File: rtl/arc4_key_search.sv
// Brute-force key search over a 24-bit range: drives arc4, then scans the PT memory
// it produces and stops at the first key whose plaintext is entirely printable ASCII.
module arc4_key_search #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_END   = 24'hFFFFFF,
    parameter logic [23:0] KEY_STEP  = 24'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        arc4_en,
    output logic [23:0] arc4_key,
    input  logic        arc4_rdy,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RD_LEN,
        S_LATCH_LEN,
        S_SCAN,
        S_NEXT,
        S_FOUND,
        S_FAIL
    } state_t;

    state_t      state_q;
    logic        rdy_q;
    logic [23:0] key_q;
    logic        key_valid_q;
    logic        arc4_en_q;
    logic [7:0]  pt_addr_q;
    logic [7:0]  len_q;
    logic [7:0]  idx_q;
    logic        wait_q;

    logic [24:0] key_sum_d;
    logic        byte_ok_d;

    // The extra top bit catches wrap-around past 24'hFFFFFF as "beyond KEY_END".
    assign key_sum_d = {1'b0, key_q} + {1'b0, KEY_STEP};
    assign byte_ok_d = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b1;
            key_q       <= 24'h000000;
            key_valid_q <= 1'b0;
            arc4_en_q   <= 1'b0;
            pt_addr_q   <= 8'h00;
            len_q       <= 8'h00;
            idx_q       <= 8'h00;
            wait_q      <= 1'b0;
        end else begin
            arc4_en_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (en) begin
                        key_q       <= KEY_START;
                        key_valid_q <= 1'b0;
                        rdy_q       <= 1'b0;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (arc4_rdy) begin
                        arc4_en_q <= 1'b1;
                        state_q   <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!arc4_rdy) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (arc4_rdy) begin
                        pt_addr_q <= 8'h00;
                        state_q   <= S_RD_LEN;
                    end
                end
                S_RD_LEN: begin
                    state_q <= S_LATCH_LEN;
                end
                S_LATCH_LEN: begin
                    len_q <= pt_rddata;
                    if (pt_rddata == 8'h00) begin
                        state_q <= S_FOUND;
                    end else begin
                        pt_addr_q <= 8'h01;
                        idx_q     <= 8'h01;
                        wait_q    <= 1'b1;
                        state_q   <= S_SCAN;
                    end
                end
                // wait_q burns the memory-latency cycle after every new address.
                S_SCAN: begin
                    if (wait_q) begin
                        wait_q <= 1'b0;
                    end else if (!byte_ok_d) begin
                        state_q <= S_NEXT;
                    end else if (idx_q == len_q) begin
                        state_q <= S_FOUND;
                    end else begin
                        idx_q     <= idx_q + 8'h01;
                        pt_addr_q <= idx_q + 8'h01;
                        wait_q    <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (key_sum_d > {1'b0, KEY_END}) begin
                        state_q <= S_FAIL;
                    end else begin
                        key_q   <= key_sum_d[23:0];
                        state_q <= S_LAUNCH;
                    end
                end
                S_FOUND: begin
                    key_valid_q <= 1'b1;
                    rdy_q       <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_FAIL: begin
                    key_valid_q <= 1'b0;
                    rdy_q       <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rdy       = rdy_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign arc4_en   = arc4_en_q;
    assign arc4_key  = key_q;
    assign pt_addr   = pt_addr_q;

endmodule

// File: tb/tb_arc4_key_search.sv
// Scoreboard bench for arc4_key_search: three parameterisations, each with a behavioural
// arc4/PT-memory model and a reference search computed straight from the plaintext images.
module tb_arc4_key_search;

    typedef struct {
        bit          found;
        logic [23:0] key;
        int          pulses;
        logic [7:0]  addr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int fails    = 0;
    int doneInst = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] printableByte();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'h20;
        if (r == 1) return 8'h7E;
        return 8'($urandom_range(32, 126));
    endfunction

    function automatic logic [7:0] badByte();
        int unsigned r;
        int unsigned v;
        r = $urandom_range(0, 7);
        case (r)
            0: return 8'h1F;
            1: return 8'h7F;
            2: return 8'h00;
            3: return 8'hFF;
            default: begin
                v = $urandom_range(0, 160);
                return (v < 32) ? 8'(v) : 8'(v + 95);
            end
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : inst
        // Instance 2 has KEY_START above KEY_END, instance 1 walks odd keys with step 2.
        localparam logic [23:0] KS = (g == 0) ? 24'h000010 : (g == 1) ? 24'h000001 : 24'h000008;
        localparam logic [23:0] KE = (g == 0) ? 24'h00001F : (g == 1) ? 24'h000005 : 24'h000004;
        localparam logic [23:0] KP = (g == 1) ? 24'd2 : 24'd1;

        logic        rst_n = 1'b0;
        logic        en    = 1'b0;
        logic        rdy;
        logic [23:0] key;
        logic        key_valid;
        logic        arc4_en;
        logic [23:0] arc4_key;
        logic        arc4Rdy;
        logic [7:0]  pt_addr;
        logic [7:0]  ptRd;

        logic [7:0]  img [32][16];
        logic [7:0]  ptMem [256];
        int          busyCnt;
        logic [23:0] curKey;

        exp_t sb[$];
        int   pulses  = 0;
        int   doneCnt = 0;
        bit   rdyPrev = 1'b1;
        bit   enPrev  = 1'b0;

        arc4_key_search #(
            .KEY_START(KS),
            .KEY_END  (KE),
            .KEY_STEP (KP)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .rdy      (rdy),
            .key      (key),
            .key_valid(key_valid),
            .arc4_en  (arc4_en),
            .arc4_key (arc4_key),
            .arc4_rdy (arc4Rdy),
            .pt_addr  (pt_addr),
            .pt_rddata(ptRd)
        );

        // arc4 stand-in: 20 busy cycles per run, then the image for that key lands in PT.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                arc4Rdy <= 1'b1;
                busyCnt <= 0;
                curKey  <= 24'h0;
            end else if (arc4_en && arc4Rdy) begin
                arc4Rdy <= 1'b0;
                busyCnt <= 20;
                curKey  <= arc4_key;
            end else if (busyCnt != 0) begin
                busyCnt <= busyCnt - 1;
                if (busyCnt == 1) begin
                    arc4Rdy <= 1'b1;
                    for (int a = 0; a < 256; a++)
                        ptMem[a] <= (a < 16) ? img[curKey[4:0]][a[3:0]] : 8'h00;
                end
            end
        end

        always @(posedge clk) ptRd <= ptMem[pt_addr];

        task automatic genImages(input bit forceGood);
            int          goodPct;
            logic [7:0]  len;
            bit          good;
            goodPct = int'($urandom_range(5, 40));
            for (int k = 0; k < 32; k++) begin
                good = (int'($urandom_range(0, 99)) < goodPct);
                len  = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
                if (forceGood && k == int'(KS[4:0])) begin
                    good = 1'b1;
                    len  = 8'd8;
                end
                img[k][0] = len;
                for (int i = 1; i < 16; i++)
                    img[k][i] = (i <= int'(len)) ? printableByte() : 8'h00;
                if (!good && len != 8'd0)
                    img[k][$urandom_range(1, int'(len))] = badByte();
            end
        endtask

        // Walk keys from KS in steps of KP; the first all-printable message wins.
        function automatic exp_t refModel();
            exp_t        e;
            logic [24:0] k;
            int          firstBad;
            int          len;
            k        = {1'b0, KS};
            e.found  = 1'b0;
            e.key    = KS;
            e.pulses = 0;
            e.addr   = 8'h00;
            for (int n = 0; n < 64; n++) begin
                e.pulses++;
                len      = int'(img[k[4:0]][0]);
                firstBad = 0;
                for (int i = 1; i <= len; i++)
                    if (firstBad == 0 && (img[k[4:0]][i] < 8'h20 || img[k[4:0]][i] > 8'h7E))
                        firstBad = i;
                e.key = k[23:0];
                if (firstBad == 0) begin
                    e.found = 1'b1;
                    e.addr  = 8'(len);
                    return e;
                end
                e.addr = 8'(firstBad);
                if (k + {1'b0, KP} > {1'b0, KE}) return e;
                k = k + {1'b0, KP};
            end
            return e;
        endfunction

        task automatic applyStimulus(input int run);
            bit rstRun;
            int startDone;
            int budget;
            rstRun = (g == 0 && run == 3);
            genImages(rstRun);
            if (!rstRun) sb.push_back(refModel());
            startDone = doneCnt;
            @(negedge clk);
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            checkOutput($sformatf("g%0d_rdy_fall", g), rdy, 1'b0);
            if (rstRun) begin
                budget = 0;
                while (arc4Rdy && budget < 500) begin @(negedge clk); budget++; end
                while (!arc4Rdy && budget < 500) begin @(negedge clk); budget++; end
                while (pt_addr != 8'd2 && budget < 500) begin @(negedge clk); budget++; end
                checkOutput($sformatf("g%0d_scan_reached", g), pt_addr, 8'd2);
                #2 rst_n = 1'b0;
                #1;
                checkOutput($sformatf("g%0d_abort_rdy", g), rdy, 1'b1);
                checkOutput($sformatf("g%0d_abort_key", g), key, 24'h0);
                checkOutput($sformatf("g%0d_abort_valid", g), key_valid, 1'b0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end else begin
                repeat ($urandom_range(3, 20)) @(negedge clk);
                en = 1'b1;
                @(negedge clk);
                en = 1'b0;
                budget = 0;
                while (doneCnt == startDone && budget < 4000) begin @(negedge clk); budget++; end
                checkOutput($sformatf("g%0d_search_done", g), doneCnt != startDone, 1'b1);
                if (doneCnt == startDone) begin
                    rst_n = 1'b0;
                    sb.delete();
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        endtask

        initial begin
            repeat (5) @(negedge clk);
            checkOutput($sformatf("g%0d_reset_rdy", g), rdy, 1'b1);
            checkOutput($sformatf("g%0d_reset_key", g), key, 24'h0);
            checkOutput($sformatf("g%0d_reset_valid", g), key_valid, 1'b0);
            checkOutput($sformatf("g%0d_reset_arc4_en", g), arc4_en, 1'b0);
            checkOutput($sformatf("g%0d_reset_pt_addr", g), pt_addr, 8'h0);
            rst_n = 1'b1;
            for (int run = 0; run < 8; run++) applyStimulus(run);
            doneInst++;
        end

        // Monitor: protocol checks on every arc4_en pulse, scoreboard pop on each rdy rise.
        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                rdyPrev = 1'b1;
                enPrev  = 1'b0;
                pulses  = 0;
            end else begin
                if (arc4_en) begin
                    pulses++;
                    checkOutput($sformatf("g%0d_arc4_en_proto", g),
                                {enPrev, !arc4Rdy, arc4_key != key}, 3'b000);
                end
                enPrev = arc4_en;
                if (!rdyPrev && rdy) begin
                    if (sb.size() == 0) begin
                        checkOutput($sformatf("g%0d_unexpected_done", g), sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        checkOutput($sformatf("g%0d_key", g), key, e.key);
                        checkOutput($sformatf("g%0d_key_valid", g), key_valid, e.found);
                        checkOutput($sformatf("g%0d_pulses", g), pulses, e.pulses);
                        checkOutput($sformatf("g%0d_last_pt_addr", g), pt_addr, e.addr);
                    end
                    pulses = 0;
                    doneCnt++;
                end
                rdyPrev = rdy;
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (doneInst < 3 && cyc < 80000) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput("all_instances_done", doneInst, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
